p2s_8x16: RTL



---
 rtl/p2s_8x16_if.sv | 34 +++
 rtl/p2s_8x16.sv | 104 ++++++++++
 2 files changed

// File: rtl/p2s_8x16_if.sv
// Handshake and data bundle for the 8-word parallel-to-serial converter.
// The master drives the load/advance controls and the parallel words.
interface p2s_8x16_if #(
    parameter int N = 4
);
    localparam int W = 1 << N;

    logic         en;
    logic         load;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic [W-1:0] x3;
    logic [W-1:0] x4;
    logic [W-1:0] x5;
    logic [W-1:0] x6;
    logic [W-1:0] x7;
    logic [W-1:0] x8;
    logic         ready;
    logic [W-1:0] y;
    logic         valid;
    logic         last;

    modport master (
        output en, load,
        output x1, x2, x3, x4, x5, x6, x7, x8,
        input  ready, y, valid, last
    );

    modport slave (
        input  en, load,
        input  x1, x2, x3, x4, x5, x6, x7, x8,
        output ready, y, valid, last
    );
endinterface

// File: rtl/p2s_8x16.sv
// Parallel-to-serial converter: one load of eight words, emitted x8 first
// and x1 last, one word per enabled clock, with valid/last/ready.
module p2s_8x16 #(
    parameter int N = 4
) (
    input logic      clk,
    input logic      rst_n,
    p2s_8x16_if.slave bus
);
    localparam int W = 1 << N;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [2:0]   cnt_q;
    logic [2:0]   cnt_d;
    logic [W-1:0] word_q [8];
    logic [W-1:0] y_q;
    logic [W-1:0] y_d;
    logic         valid_q;
    logic         valid_d;
    logic         final_beat;
    logic         capture;
    logic         advance;

    assign final_beat = (state_q == SHIFT) && (cnt_q == 3'd7) && bus.en;
    assign capture    = bus.load && bus.ready;
    assign advance    = (state_q == SHIFT) && bus.en && (cnt_q != 3'd7);

    assign bus.ready = (state_q == IDLE) || final_beat;
    assign bus.y     = y_q;
    assign bus.valid = valid_q;
    assign bus.last  = valid_q && (cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.load) state_d = SHIFT;
            end
            SHIFT: begin
                if (final_beat && !bus.load) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // word_q[0] holds x1, word_q[7] holds x8; beat k shows word_q[7-k]
    always_comb begin
        cnt_d   = cnt_q;
        y_d     = y_q;
        valid_d = valid_q;
        if (capture) begin
            cnt_d   = 3'd0;
            y_d     = bus.x8;
            valid_d = 1'b1;
        end else if (advance) begin
            cnt_d = cnt_q + 3'd1;
            y_d   = word_q[3'd6 - cnt_q];
        end else if (final_beat) begin
            cnt_d   = 3'd0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 3'd0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) word_q[i] <= '0;
        end else if (capture) begin
            word_q[0] <= bus.x1;
            word_q[1] <= bus.x2;
            word_q[2] <= bus.x3;
            word_q[3] <= bus.x4;
            word_q[4] <= bus.x5;
            word_q[5] <= bus.x6;
            word_q[6] <= bus.x7;
            word_q[7] <= bus.x8;
        end
    end
endmodule
